// File: rtl/reg_file_loader_if.sv
// Bundle of the loader's control, stream and register-file write-port signals.
// master: word source / test side; slave: the loader itself.
interface reg_file_loader_if #(
    parameter int WIDTH_ADDR   = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32
);
    logic                         start;
    logic [WIDTH_ADDR-1:0]        start_addr;
    logic [N-1:0]                 s_data;
    logic                         s_valid;
    logic                         s_last;
    logic                         s_ready;
    logic [WIDTH_VECTOR-1:0]      wec;
    logic [WIDTH_ADDR-1:0]        addrc;
    logic [WIDTH_VECTOR*N-1:0]    wdata_c;
    logic                         busy;
    logic                         done;
    logic [WIDTH_ADDR:0]          vec_count;

    modport master (
        output start, start_addr, s_data, s_valid, s_last,
        input  s_ready, wec, addrc, wdata_c, busy, done, vec_count
    );

    modport slave (
        input  start, start_addr, s_data, s_valid, s_last,
        output s_ready, wec, addrc, wdata_c, busy, done, vec_count
    );
endinterface

// File: rtl/reg_file_loader.sv
// Packs a word stream lane by lane into vectors and writes them to the register file.
// Option: REG_FILE_LOADER_ZERO_FILL_EN makes every write full-width, zeroing unfilled lanes.
module reg_file_loader #(
    parameter int WIDTH_ADDR   = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_file_loader_if.slave   bus
);

    localparam int LW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(WIDTH_VECTOR - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                      state_q;
    logic [WIDTH_ADDR-1:0]       addr_q;
    logic [WIDTH_ADDR-1:0]       addrc_q;
    logic [LW-1:0]               lane_q;
    logic [WIDTH_VECTOR-1:0]     mask_q;
    logic [WIDTH_VECTOR-1:0]     wec_q;
    logic [WIDTH_VECTOR*N-1:0]   buf_q;
    logic [WIDTH_VECTOR*N-1:0]   wdata_q;
    logic                        last_seen_q;
    logic [WIDTH_ADDR:0]         cnt_q;

    logic                        xfer;
    logic                        vec_end;
    logic [WIDTH_VECTOR*N-1:0]   buf_d;
    logic [WIDTH_VECTOR-1:0]     mask_d;
    logic [WIDTH_VECTOR*N-1:0]   wdata_d;
    logic [WIDTH_VECTOR-1:0]     wec_d;

    // Status outputs decode straight from the registered state.
    assign bus.s_ready   = (state_q == FILL);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.wec       = wec_q;
    assign bus.addrc     = addrc_q;
    assign bus.wdata_c   = wdata_q;
    assign bus.vec_count = cnt_q;

    // Buffer/mask with the current word merged in, and the write image built from them.
    always_comb begin
        xfer    = (state_q == FILL) && bus.s_valid;
        vec_end = xfer && ((lane_q == LANE_MAX) || bus.s_last);
        buf_d   = buf_q;
        mask_d  = mask_q;
        if (xfer) begin
            buf_d[int'(lane_q)*N +: N] = bus.s_data;
            mask_d[lane_q]             = 1'b1;
        end
        wdata_d = buf_d;
        wec_d   = mask_d;
`ifdef REG_FILE_LOADER_ZERO_FILL_EN
        wec_d = '1;
        for (int i = 0; i < WIDTH_VECTOR; i++) begin
            if (!mask_d[i]) begin
                wdata_d[i*N +: N] = '0;
            end
        end
`endif
    end

    // Sequencer: fill lanes, issue one write per vector, signal completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            addrc_q     <= '0;
            lane_q      <= '0;
            mask_q      <= '0;
            wec_q       <= '0;
            buf_q       <= '0;
            wdata_q     <= '0;
            last_seen_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q      <= bus.start_addr;
                        lane_q      <= '0;
                        mask_q      <= '0;
                        cnt_q       <= '0;
                        last_seen_q <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        buf_q  <= buf_d;
                        mask_q <= mask_d;
                        lane_q <= lane_q + 1'b1;
                        if (bus.s_last) begin
                            last_seen_q <= 1'b1;
                        end
                    end
                    if (vec_end) begin
                        wec_q   <= wec_d;
                        addrc_q <= addr_q;
                        wdata_q <= wdata_d;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    wec_q  <= '0;
                    addr_q <= addr_q + 1'b1;
                    lane_q <= '0;
                    mask_q <= '0;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    state_q <= last_seen_q ? DONE : FILL;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_loader.sv
// Scoreboard bench for reg_file_loader: driver pushes expected writes/done,
// monitor pops and compares whenever the DUT writes or signals done.
module tb_reg_file_loader;

`ifdef REG_FILE_LOADER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct {
        logic [3:0]   addr;
        logic [7:0]   wec;
        logic [255:0] data;
        logic [255:0] care;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_loader_if bus ();

    reg_file_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int last_wr_cyc = -100;

    wr_t exp_wr[$];
    int  exp_done[$];
    logic [31:0] words[$];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        total++;
        $display("FAIL %s", nm);
    endtask

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("s_ready", 256'(bus.s_ready),
                256'(bus.busy && bus.wec == 8'h00 && !bus.done));
            if (bus.wec != 8'h00) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("addrc", 256'(bus.addrc), 256'(e.addr));
                    chk("wec", 256'(bus.wec), 256'(e.wec));
                    chk("wdata", bus.wdata_c & e.care, e.data);
                end
                last_wr_cyc = cyc;
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    int v;
                    v = exp_done.pop_front();
                    chk("vec_count", 256'(bus.vec_count), 256'(v));
                    chk("done_latency", 256'(cyc - last_wr_cyc), 256'(1));
                end
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy) fail_now("idle_timeout");
    endtask

    // Reference model: vector k goes to start+k, holding words[8k .. 8k+7].
    task automatic model(input int addr);
        int n, nv, cnt;
        wr_t e;
        n  = words.size();
        nv = (n + 7) / 8;
        for (int k = 0; k < nv; k++) begin
            cnt = n - 8 * k;
            if (cnt > 8) cnt = 8;
            e.addr = 4'((addr + k) % 16);
            e.wec  = '0;
            e.data = '0;
            e.care = '0;
            for (int l = 0; l < cnt; l++) begin
                e.data[l*32 +: 32] = words[8*k + l];
                e.care[l*32 +: 32] = '1;
                e.wec[l] = 1'b1;
            end
            if (ZF) begin
                e.wec  = 8'hFF;
                e.care = '1;
            end
            exp_wr.push_back(e);
        end
        exp_done.push_back(nv > 31 ? 31 : nv);
    endtask

    // mode 0: back to back, 1: valid 1,0,0,1 pattern, 2: random gaps
    task automatic run_load(input int addr, input int mode, input bit inj,
                            input int abort_after);
        int n, i, c, g;
        bit injected;
        n = words.size();
        wait_idle();
        if (abort_after == 0) model(addr);
        bus.start = 1'b1;
        bus.start_addr = 4'(addr);
        @(negedge clk);
        bus.start = 1'b0;
        i = 0; c = 0; g = 0; injected = 0;
        while (i < n && g < 5000) begin
            g++;
            if (abort_after != 0 && i == abort_after) break;
            if (inj && i == 2 && !injected) begin
                injected = 1;
                bus.start = 1'b1;
                bus.start_addr = 4'($urandom_range(0, 15));
                bus.s_valid = 1'b0;
                @(negedge clk);
                bus.start = 1'b0;
                continue;
            end
            if ((mode == 1 && !(c % 4 == 0 || c % 4 == 3)) ||
                (mode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.s_valid = 1'b0;
                c++;
                @(negedge clk);
                continue;
            end
            c++;
            bus.s_valid = 1'b1;
            bus.s_data  = words[i];
            bus.s_last  = (abort_after == 0) && (i == n - 1);
            if (bus.s_ready) i++;
            @(negedge clk);
        end
        if (g >= 5000) fail_now("feed_timeout");
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (abort_after == 0) wait_idle();
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", 256'(bus.s_ready), 256'(0));
        chk("rst_wec", 256'(bus.wec), 256'(0));
        chk("rst_addrc", 256'(bus.addrc), 256'(0));
        chk("rst_wdata", bus.wdata_c, 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_vec_count", 256'(bus.vec_count), 256'(0));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        words = {};
        for (int k = 1; k <= 8; k++) words.push_back(32'(k));
        run_load(3, 0, 0, 0);

        words = {};
        for (int k = 1; k <= 11; k++) words.push_back(32'(k));
        run_load(0, 0, 0, 0);

        words = {};
        for (int k = 0; k < 16; k++) words.push_back($urandom);
        run_load(15, 0, 0, 0);

        words = {};
        for (int k = 0; k < 8; k++) words.push_back($urandom);
        run_load(6, 1, 0, 0);

        words = {};
        for (int k = 0; k < 8; k++) words.push_back($urandom);
        run_load(5, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        words = {};
        for (int k = 0; k < 2; k++) words.push_back($urandom);
        run_load(9, 0, 0, 0);

        words = {};
        for (int k = 0; k < 12; k++) words.push_back($urandom);
        run_load(12, 2, 1, 0);

        for (int t = 0; t < 12; t++) begin
            words = {};
            for (int k = 0; k < int'($urandom_range(1, 40)); k++)
                words.push_back($urandom);
            run_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 0);
        end

        words = {};
        for (int k = 0; k < 264; k++) words.push_back($urandom);
        run_load(7, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("pending_writes", 256'(exp_wr.size()), 256'(0));
        chk("pending_done", 256'(exp_done.size()), 256'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
